// File: rtl/npc_pkg.sv
// Types and constants shared by the fetch and next-PC stages.
package npc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    HOLD = 2'd3
  } ifu_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [1:0]  RESP_OKAY        = 2'b00;

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding read per instruction, with
// misalignment, bus-error and timeout reporting through fetch_err.
module ifu
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dnpc_valid,
  input  logic [31:0] dnpc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  mem_rresp,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic [31:0] snpc,
  output logic        fetch_err
);

  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  ifu_state_t        state, state_next;
  logic [CNT_W-1:0]  wait_cnt;
  logic              pc_load;
  logic              inst_load;
  logic [31:0]       inst_d;
  logic              err_d;
  logic              cnt_clr;
  logic              cnt_inc;

  always_ff @(posedge clk) begin
    if (rst) state <= ADDR;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    pc_load    = 1'b0;
    inst_load  = 1'b0;
    inst_d     = '0;
    err_d      = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (dnpc_valid) begin
          pc_load = 1'b1;
          if (dnpc[1:0] == 2'b00) begin
            state_next = ADDR;
          end else begin
            // Misaligned target never reaches the bus; report it directly.
            inst_load  = 1'b1;
            err_d      = 1'b1;
            state_next = HOLD;
          end
        end
      end
      ADDR: begin
        mem_req = 1'b1;
        if (mem_gnt) begin
          cnt_clr    = 1'b1;
          state_next = DATA;
        end
      end
      DATA: begin
        if (mem_rvalid) begin
          inst_load  = 1'b1;
          inst_d     = mem_rdata;
          err_d      = (mem_rresp != RESP_OKAY);
          state_next = HOLD;
        end else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
          // This is the MAX_WAIT-th empty data cycle: give up on the fetch.
          inst_load  = 1'b1;
          err_d      = 1'b1;
          state_next = HOLD;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      HOLD: begin
        if (inst_ready) state_next = IDLE;
      end
      default: state_next = ADDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      inst      <= '0;
      fetch_err <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      if (pc_load) pc <= dnpc;
      if (inst_load) begin
        inst      <= inst_d;
        fetch_err <= err_d;
      end
      if (cnt_clr)      wait_cnt <= '0;
      else if (cnt_inc) wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign mem_addr   = pc;
  assign snpc       = pc + 32'd4;
  assign inst_valid = (state == HOLD);

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: a transaction-level reference checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_ifu;

  localparam int          MW  = 6;
  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst, dnpc_valid, mem_gnt, mem_rvalid, inst_ready;
  logic [31:0] dnpc, mem_rdata;
  logic [1:0]  mem_rresp;
  logic        mem_req, inst_valid, fetch_err;
  logic [31:0] mem_addr, inst, pc, snpc;

  int errors = 0;
  int checks = 0;
  int dut_acc = 0;
  bit check_en = 0;

  ifu #(.RESET_PC(RPC), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .dnpc_valid(dnpc_valid), .dnpc(dnpc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rresp(mem_rresp),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .pc(pc), .snpc(snpc), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what the fetch unit owes the outside world, one fetch at a time.
  bit          want_grant, want_data, presenting;
  int          waited;
  logic [31:0] m_pc, m_inst;
  logic        m_err;

  always @(posedge clk) begin
    if (rst) begin
      m_pc = RPC; want_grant = 1; want_data = 0; presenting = 0;
      m_inst = 0; m_err = 0; waited = 0;
      check_en = 1;
    end else if (presenting) begin
      if (inst_ready) presenting = 0;
    end else if (want_grant) begin
      if (mem_gnt) begin want_grant = 0; want_data = 1; waited = 0; end
    end else if (want_data) begin
      if (mem_rvalid) begin
        m_inst = mem_rdata; m_err = (mem_rresp != 2'b00);
        want_data = 0; presenting = 1;
      end else begin
        waited++;
        if (waited == MW) begin
          m_inst = 0; m_err = 1; want_data = 0; presenting = 1;
        end
      end
    end else if (dnpc_valid) begin
      m_pc = dnpc;
      if (dnpc % 4 == 0) want_grant = 1;
      else begin m_inst = 0; m_err = 1; presenting = 1; end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("mem_req", {31'd0, mem_req}, {31'd0, want_grant});
      chk("pc", pc, m_pc);
      chk("snpc", snpc, m_pc + 32'd4);
      if (want_grant) chk("mem_addr", mem_addr, m_pc);
      chk("inst_valid", {31'd0, inst_valid}, {31'd0, presenting});
      if (presenting) begin
        chk("inst", inst, m_inst);
        chk("fetch_err", {31'd0, fetch_err}, {31'd0, m_err});
      end
      if (mem_req && mem_gnt) dut_acc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept();
    inst_ready = 1; step(); inst_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc0;
    rst = 1; dnpc_valid = 0; dnpc = 0; mem_gnt = 0; mem_rvalid = 0;
    mem_rdata = 0; mem_rresp = 0; inst_ready = 0;
    step(); step(); step();

    // Reset state and first fetch from RESET_PC, grant and data 1 cycle late.
    @(negedge clk);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_pc", pc, 32'h8000_0000);
    #1 rst = 0;
    @(negedge clk);
    chk("boot_req", {31'd0, mem_req}, 32'd1);
    chk("boot_addr", mem_addr, 32'h8000_0000);
    step(); mem_gnt = 1;
    step(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0413;
    step(); mem_rvalid = 0;
    @(negedge clk);
    chk("boot_valid", {31'd0, inst_valid}, 32'd1);
    chk("boot_inst", inst, 32'h0000_0413);
    chk("boot_snpc", snpc, 32'h8000_0004);
    #1 accept();

    // Grant delayed 4 cycles: address stable, exactly one accepted request.
    acc0 = dut_acc;
    dnpc_valid = 1; dnpc = 32'h8000_0010;
    step(); dnpc_valid = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) mem_gnt = 1;
      @(negedge clk);
      chk("gnt_wait_addr", mem_addr, 32'h8000_0010);
      step();
    end
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0010_0093;
    step(); mem_rvalid = 0;
    chk("one_accept", dut_acc - acc0, 32'd1);

    // Stall in HOLD while a dnpc pulse arrives.
    for (int i = 0; i < 6; i++) begin
      dnpc_valid = (i == 2 || i == 3); dnpc = 32'h8000_0100;
      @(negedge clk);
      chk("stall_pc", pc, 32'h8000_0010);
      chk("stall_inst", inst, 32'h0010_0093);
      step();
    end
    dnpc_valid = 0;
    accept();
    @(negedge clk);
    chk("post_accept_valid", {31'd0, inst_valid}, 32'd0);
    chk("post_accept_req", {31'd0, mem_req}, 32'd0);

    // Misaligned target goes straight to HOLD with an error.
    #1 dnpc_valid = 1; dnpc = 32'h8000_0002;
    @(negedge clk);
    chk("misal_noreq", {31'd0, mem_req}, 32'd0);
    #1 step(); dnpc_valid = 0;
    @(negedge clk);
    chk("misal_valid", {31'd0, inst_valid}, 32'd1);
    chk("misal_err", {31'd0, fetch_err}, 32'd1);
    chk("misal_inst", inst, 32'd0);
    chk("misal_pc", pc, 32'h8000_0002);
    chk("misal_noreq2", {31'd0, mem_req}, 32'd0);
    #1 accept();

    // Grant and rvalid together count as grant only; then timeout.
    dnpc_valid = 1; dnpc = 32'h8000_0020;
    step(); dnpc_valid = 0;
    mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
    step(); mem_gnt = 0; mem_rvalid = 0;
    for (int i = 0; i < MW - 1; i++) step();
    @(negedge clk);
    chk("to_not_yet", {31'd0, inst_valid}, 32'd0);
    #1 step();
    @(negedge clk);
    chk("to_valid", {31'd0, inst_valid}, 32'd1);
    chk("to_err", {31'd0, fetch_err}, 32'd1);
    chk("to_inst", inst, 32'd0);
    #1 mem_rvalid = 1; mem_rdata = 32'h1234_5678;
    step(); mem_rvalid = 0;
    chk("late_hold_inst", inst, 32'd0);
    accept();
    mem_rvalid = 1; mem_rresp = 2'b00;
    step(); mem_rvalid = 0;
    chk("late_idle_req", {31'd0, mem_req}, 32'd0);

    // Data on the last allowed wait cycle wins over the timeout.
    dnpc_valid = 1; dnpc = 32'h8000_0024;
    step(); dnpc_valid = 0; mem_gnt = 1;
    step(); mem_gnt = 0;
    for (int i = 0; i < MW - 1; i++) step();
    mem_rvalid = 1; mem_rdata = 32'h0052_8293;
    step(); mem_rvalid = 0;
    chk("edge_inst", inst, 32'h0052_8293);
    chk("edge_err", {31'd0, fetch_err}, 32'd0);
    accept();

    // Bus error response keeps the data but flags it.
    dnpc_valid = 1; dnpc = 32'h8000_0030;
    step(); dnpc_valid = 0; mem_gnt = 1;
    step(); mem_gnt = 0; mem_rvalid = 1; mem_rresp = 2'b10; mem_rdata = 32'hCAFE_F00D;
    step(); mem_rvalid = 0; mem_rresp = 2'b00;
    chk("berr_err", {31'd0, fetch_err}, 32'd1);
    chk("berr_inst", inst, 32'hCAFE_F00D);
    accept();

    // Reset during DATA restarts at RESET_PC; a stale rvalid is ignored.
    dnpc_valid = 1; dnpc = 32'h8000_0040;
    step(); dnpc_valid = 0; mem_gnt = 1;
    step(); mem_gnt = 0; rst = 1;
    step(); rst = 0;
    @(negedge clk);
    chk("rst_mid_req", {31'd0, mem_req}, 32'd1);
    chk("rst_mid_addr", mem_addr, 32'h8000_0000);
    #1 mem_rvalid = 1; mem_rdata = 32'hBAD0_BAD0;
    step(); mem_rvalid = 0; mem_gnt = 1;
    step(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0013;
    step(); mem_rvalid = 0;
    chk("rst_mid_inst", inst, 32'h0000_0013);
    accept();

    // snpc wraps at the top of the address space.
    dnpc_valid = 1; dnpc = 32'hFFFF_FFFC;
    step(); dnpc_valid = 0;
    @(negedge clk);
    chk("wrap_addr", mem_addr, 32'hFFFF_FFFC);
    chk("wrap_snpc", snpc, 32'h0000_0000);
    #1 mem_gnt = 1;
    step(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0073;
    step(); mem_rvalid = 0;
    accept();
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h80000000, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter MAX_WAIT, default 255, giving the maximum number of DATA-state cycles before a fetch timeout.
REQ-003 clk  in  1  sole clock; all state changes on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 dnpc_valid  in  1  next PC from the next-PC stage is valid this cycle.
REQ-006 dnpc  in  32  next PC value.
REQ-007 mem_req  out  1  instruction-memory read request.
REQ-008 mem_addr  out  32  request address; equals pc.
REQ-009 mem_gnt  in  1  memory accepts the request this cycle.
REQ-010 mem_rvalid  in  1  read data valid.
REQ-011 mem_rdata  in  32  read data.
REQ-012 mem_rresp  in  2  response code; 2'b00 = OKAY, anything else = error.
REQ-013 inst_valid  out  1  fetched instruction is available to decode.
REQ-014 inst_ready  in  1  decode accepts the instruction.
REQ-015 inst  out  32  fetched instruction word.
REQ-016 pc  out  32  address of inst.
REQ-017 snpc  out  32  pc + 4, consumed by the next-PC stage.
REQ-018 fetch_err  out  1  the held instruction is invalid: misaligned, bus error or timeout.

Function
REQ-019 The FSM SHALL have the states IDLE, ADDR, DATA and HOLD.
REQ-020 IDLE: the FSM SHALL move to ADDR with pc <= dnpc in the cycle after dnpc_valid=1 and dnpc[1:0]==0.
REQ-021 IDLE: if dnpc_valid=1 and dnpc[1:0]!=0, the FSM SHALL load pc <= dnpc, set fetch_err=1 and inst=0, and go directly to HOLD without asserting mem_req.
REQ-022 ADDR: mem_req SHALL be 1 and mem_addr SHALL be held stable until mem_gnt=1, after which the FSM SHALL enter DATA.
REQ-023 DATA: on mem_rvalid=1 the block SHALL register inst <= mem_rdata and fetch_err <= (mem_rresp!=0), then enter HOLD; inst_valid SHALL rise exactly one cycle after mem_rvalid.
REQ-024 DATA: a wait counter SHALL clear on entry and increment each cycle without mem_rvalid.
REQ-025 DATA: when the wait counter reaches MAX_WAIT, the block SHALL set fetch_err=1 and inst=0 and enter HOLD.
REQ-026 HOLD: inst_valid SHALL be 1, and inst, pc and fetch_err SHALL be stable until inst_ready=1.
REQ-027 HOLD: on inst_ready=1 the FSM SHALL go to IDLE and inst_valid SHALL be 0 the next cycle.
REQ-028 dnpc_valid in any state other than IDLE SHALL be ignored.
REQ-029 mem_rvalid in any state other than DATA SHALL be ignored, including a late response after a timeout.
REQ-030 mem_gnt and mem_rvalid asserted in the same ADDR cycle SHALL be treated as grant only; data is expected in DATA.
REQ-031 snpc SHALL be computed combinationally as pc+4, modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-032 Best-case latency from dnpc_valid to inst_valid SHALL be 3 cycles, with mem_gnt and mem_rvalid each answered in one cycle.

Reset
REQ-033 While rst=1, the block SHALL hold pc=RESET_PC, state=ADDR, inst=0, inst_valid=0, fetch_err=0 and wait counter=0.
REQ-034 Because state resets to ADDR, the first cycle after reset release SHALL have mem_req=1 and mem_addr=RESET_PC without requiring dnpc_valid.
REQ-035 rst asserted mid-transaction SHALL abandon the transaction, and any subsequent rvalid SHALL be ignored per REQ-029.

Structure
REQ-036 The shared package npc_pkg SHALL hold the state enum ifu_state_t, the constant RESET_PC_DEFAULT and the constant RESP_OKAY.
REQ-037 The block SHALL contain no sub-module; the wait counter and FSM are inline.

Verification
REQ-038 Reset release, gnt and rvalid each 1 cycle later, rdata=32'h00000413 -> mem_addr=32'h80000000; inst_valid on cycle 3 with inst=32'h00000413, snpc=32'h80000004.
REQ-039 dnpc=32'h80000010 with gnt delayed 4 cycles -> mem_addr stable for all 5 request cycles; one request is accepted.
REQ-040 inst_ready held 0 for 6 cycles while dnpc_valid pulses -> inst, pc and inst_valid are stable; the dnpc pulse is ignored.
REQ-041 dnpc=32'h80000002 -> no mem_req; next cycle inst_valid=1, fetch_err=1, inst=0, pc=32'h80000002.
REQ-042 No rvalid for MAX_WAIT cycles -> fetch_err=1, inst=0; a late rvalid in HOLD or IDLE changes nothing.
REQ-043 mem_rresp=2'b10 -> fetch_err=1 with inst=rdata; rst during DATA -> next cycle mem_req=1 at RESET_PC.
